// File: rtl/mux_result_checker.sv
// mux_result_checker
// Watches a multiplexed 3-bit result bus that carries either traffic light
// codes (sel=1) or dice values (sel=0). It locks onto the current source,
// checks every sample for legal codes and legal sequencing, and reports the
// first error cause in a sticky flag/code pair.
//
// Optional feature: define ERR_CNT_EN to add an 8-bit saturating err_cnt
// output that counts every erroneous sample, not just the first.
module mux_result_checker #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [2:0] result,
    input  logic       clear,
    output logic       locked,
    output logic [1:0] light_phase,
    output logic [2:0] dice_val,
    output logic       err,
    output logic [1:0] err_code
`ifdef ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LIGHTS   = 2'd1,
        DICE     = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_BADTRAN = 2'b10;
    localparam logic [1:0] CODE_STUCK   = 2'b11;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state;
    logic       prev_sel;
    logic [7:0] hold_cnt;

    logic       light_legal;
    logic [1:0] light_code_phase;
    logic       dice_legal;
    logic       sample_legal;
    logic       first_sample;
    logic       light_hold;
    logic       light_adv;
    logic       dice_hold;
    logic       dice_adv;
    logic [7:0] hold_next;
    logic       stuck_hit;
    logic       smp_err;
    logic [1:0] smp_cause;

    // Decode the light code into a phase number; anything outside the four
    // legal lamp patterns is flagged illegal.
    always_comb begin
        light_legal      = 1'b1;
        light_code_phase = 2'd0;
        case (result)
            3'b100:  light_code_phase = 2'd0;
            3'b110:  light_code_phase = 2'd1;
            3'b001:  light_code_phase = 2'd2;
            3'b010:  light_code_phase = 2'd3;
            default: light_legal      = 1'b0;
        endcase
    end

    // Classify the current sample against the stored reference. The stored
    // light_phase/dice_val registers double as the transition reference.
    always_comb begin
        dice_legal   = (result >= 3'd1) && (result <= 3'd6);
        sample_legal = sel ? light_legal : dice_legal;
        first_sample = (state == UNLOCKED) || (sel != prev_sel);

        light_hold = (light_code_phase == light_phase);
        light_adv  = (light_code_phase == light_phase + 2'd1);

        dice_hold = (result == dice_val);
        dice_adv  = (dice_val == 3'd6) ? (result == 3'd1)
                                       : (result == dice_val + 3'd1);

        hold_next = hold_cnt + 8'd1;
        stuck_hit = (hold_next == HOLD_LIM);
    end

    // Work out whether this sample is erroneous and, if so, which cause.
    // The three causes are mutually exclusive for any one sample.
    always_comb begin
        smp_err   = 1'b0;
        smp_cause = CODE_NONE;
        if (!sample_legal) begin
            smp_err   = 1'b1;
            smp_cause = CODE_ILLEGAL;
        end else if (!first_sample) begin
            if (sel) begin
                if (!(light_hold || light_adv)) begin
                    smp_err   = 1'b1;
                    smp_cause = CODE_BADTRAN;
                end else if (light_hold && stuck_hit) begin
                    smp_err   = 1'b1;
                    smp_cause = CODE_STUCK;
                end
            end else if (!(dice_hold || dice_adv)) begin
                smp_err   = 1'b1;
                smp_cause = CODE_BADTRAN;
            end
        end
    end

    // Main checker FSM: lock/unlock, reference capture, hold counting and
    // sticky error reporting. clear wins over the sample taken that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNLOCKED;
            locked      <= 1'b0;
            prev_sel    <= 1'b0;
            hold_cnt    <= 8'd0;
            light_phase <= 2'd0;
            dice_val    <= 3'd0;
            err         <= 1'b0;
            err_code    <= CODE_NONE;
        end else if (clear) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            hold_cnt <= 8'd0;
            err      <= 1'b0;
            err_code <= CODE_NONE;
        end else begin
            prev_sel <= sel;

            if (smp_err) begin
                err <= 1'b1;
                if (!err) begin
                    err_code <= smp_cause;
                end
            end

            if (!sample_legal) begin
                state    <= UNLOCKED;
                locked   <= 1'b0;
                hold_cnt <= 8'd0;
            end else if (sel) begin
                state       <= LIGHTS;
                locked      <= 1'b1;
                light_phase <= light_code_phase;
                if (!first_sample && light_hold && !stuck_hit) begin
                    hold_cnt <= hold_next;
                end else begin
                    hold_cnt <= 8'd0;
                end
            end else begin
                state    <= DICE;
                locked   <= 1'b1;
                dice_val <= result;
                hold_cnt <= 8'd0;
            end
        end
    end

`ifdef ERR_CNT_EN
    // Count every erroneous sample, saturating so a long fault run cannot
    // wrap the count back to a small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (clear) begin
            err_cnt <= 8'd0;
        end else if (smp_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
